// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and Gray-code helpers
package fifo_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 8;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix-XOR from the MSB down; callers zero-extend narrower pointers.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      b = b ^ (b >> 1);
      b = b ^ (b >> 2);
      b = b ^ (b >> 4);
      b = b ^ (b >> 8);
      b = b ^ (b >> 16);
      return b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot selector, search starts at rr_ptr
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic [NUM_REQ-1:0]   rot_req;
   logic [NUM_REQ-1:0]   rot_gnt;
   logic [2*NUM_REQ-1:0] dbl_gnt;

   // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      rot_req = NUM_REQ'({req, req} >> rr_ptr);
      rot_gnt = rot_req & (~rot_req + 1'b1);
      dbl_gnt = {{NUM_REQ{1'b0}}, rot_gnt} << rr_ptr;
      gnt     = dbl_gnt[NUM_REQ-1:0] | dbl_gnt[2*NUM_REQ-1:NUM_REQ];
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbitrated write side of an async FIFO
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REQ    = 4,
   parameter int AF_LEVEL   = 12
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [ADDR_WIDTH:0]           wq2_rptr,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wen,
   output logic [ADDR_WIDTH-1:0]         waddr,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [ADDR_WIDTH:0]           wptr,
   output logic                          wfull,
   output logic                          almost_full
);

   localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW   = ADDR_WIDTH + 1;

   logic [PW-1:0]      wbin;
   logic [PW-1:0]      wbin_next;
   logic [PW-1:0]      wgray_next;
   logic [PW-1:0]      rbin;
   logic [PW-1:0]      occ_next;
   logic [NUM_REQ-1:0] arb_req;
   logic [RR_W-1:0]    rr_ptr;
   logic [RR_W-1:0]    rr_next;
   logic               wfull_next;
   logic               af_next;

   // Masking the requests keeps grants off while full or held in reset.
   assign arb_req = (wfull || !wrst_n) ? '0 : req;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (RR_W)
   ) u_rr_arbiter (
      .req    (arb_req),
      .rr_ptr (rr_ptr),
      .gnt    (gnt)
   );

   assign wen   = |gnt;
   assign waddr = wbin[ADDR_WIDTH-1:0];

   always_comb begin
      wdata   = '0;
      rr_next = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            wdata   = wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            rr_next = (i == NUM_REQ - 1) ? '0 : RR_W'(i + 1);
         end
      end
   end

   // Full compares against the read pointer advanced by one lap: the top two Gray bits invert.
   always_comb begin
      wbin_next  = wbin + PW'(wen);
      wgray_next = PW'(bin2gray(32'(wbin_next)));
      rbin       = PW'(gray2bin(32'(wq2_rptr)));
      occ_next   = wbin_next - rbin;
      wfull_next = (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]});
      af_next    = (32'(occ_next) >= 32'(AF_LEVEL));
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin        <= '0;
         wptr        <= '0;
         wfull       <= 1'b0;
         almost_full <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         wbin        <= wbin_next;
         wptr        <= wgray_next;
         wfull       <= wfull_next;
         almost_full <= af_next;
         if (wen) begin
            rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning FIFO depth is 2**ADDR_WIDTH and pointers are ADDR_WIDTH+1 bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the width of one FIFO word.
REQ-003 SHALL have parameter NUM_REQ, default 4, meaning the number of write requesters sharing the FIFO write port.
REQ-004 SHALL have parameter AF_LEVEL, default 12, meaning the occupancy at or above which almost_full asserts.
REQ-005 SHALL have port wclk, input, 1, meaning the single write-domain clock; all logic is on posedge wclk.
REQ-006 SHALL have port wrst_n, input, 1, meaning the asynchronous active-low reset.
REQ-007 SHALL have port req, input, NUM_REQ, meaning per-requester write request, held high until granted.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, meaning packed write data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port wq2_rptr, input, ADDR_WIDTH+1, meaning the Gray read pointer already two-flop synchronised into wclk.
REQ-010 SHALL have port gnt, output, NUM_REQ, meaning one-hot grant; a write is accepted at the edge where gnt[i] is high.
REQ-011 SHALL have port wen, output, 1, meaning the memory write enable, equal to OR of gnt.
REQ-012 SHALL have port waddr, output, ADDR_WIDTH, meaning the memory write address (low bits of the binary write pointer).
REQ-013 SHALL have port wdata, output, DATA_WIDTH, meaning the granted requester's data, valid while wen is high.
REQ-014 SHALL have port wptr, output, ADDR_WIDTH+1, meaning the registered Gray write pointer sent to the read-domain synchroniser.
REQ-015 SHALL have port wfull, output, 1, meaning the registered FIFO full flag.
REQ-016 SHALL have port almost_full, output, 1, meaning the registered occupancy >= AF_LEVEL flag.

Function
REQ-017 gnt SHALL be combinational from req, wfull and the round-robin pointer; gnt is all-zero when wfull=1 or req=0.
REQ-018 Arbitration SHALL be round-robin: search starts at index rr_ptr, wraps modulo NUM_REQ; after a grant to i, rr_ptr becomes (i+1) mod NUM_REQ at that edge; rr_ptr unchanged when no grant.
REQ-019 At most one write SHALL occur per cycle; binary pointer wbin increments by 1 at each edge with wen=1, wrapping from 2**(ADDR_WIDTH+1)-1 to 0.
REQ-020 wptr SHALL be registered as bin2gray(wbin_next) so that it changes by exactly one bit per write.
REQ-021 wfull SHALL be registered as (gray(wbin_next) == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
REQ-022 almost_full SHALL be registered as (wbin_next - gray2bin(wq2_rptr)) mod 2**(ADDR_WIDTH+1) >= AF_LEVEL.
REQ-023 wfull SHALL deassert at the first edge after wq2_rptr advances while no write is accepted; full is pessimistic, never optimistic.
REQ-024 No write SHALL be accepted in any cycle where wfull=1, regardless of req.
REQ-025 Withdrawing req before grant SHALL be legal and cause no write.

Reset
REQ-026 On wrst_n low, immediately: wbin=0, wptr=0, wfull=0, almost_full=0, rr_ptr=0; gnt and wen are 0 while reset is asserted.
REQ-027 Reset assertion mid-write SHALL discard the in-flight write; no partial pointer update.
REQ-028 Reset deassertion SHALL be used as-is; it is synchronised upstream.

Structure
REQ-029 Package fifo_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH and functions bin2gray and gray2bin.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (req, rr_ptr in; one-hot gnt out), instantiated once.

Verification
REQ-031 Reset: assert wrst_n=0 mid-run -> wptr=0, wfull=0, almost_full=0, gnt=0 immediately.
REQ-032 req=4'b0001, wq2_rptr=0 -> 16 grants, wptr after 16th write=5'b11000, wfull=1, almost_full=1 after 12th write, gnt=0 thereafter.
REQ-033 req=4'b1111 held, FIFO not full -> grant order 0,1,2,3,0,1 on consecutive edges, wdata matching each slice.
REQ-034 Full state, wq2_rptr set to 5'b00001 -> wfull=0 next edge, exactly one more grant, wfull=1 again.
REQ-035 Reader tracking writer (wq2_rptr=wptr delayed 2 cycles), 40 writes -> wptr wraps through 5'b00000 at write 32, wfull never asserts.
REQ-036 req=4'b0100 dropped before grant while wfull=1 -> no write, wptr unchanged.
